// File: rtl/hex_sequence_player.sv
// hex_sequence_player: programmable digit sequencer with per-step dwell,
// direction, loop/one-shot, pause and abort.
// Optional build macro: SEG7_EN adds a registered 7-segment glyph output
// (seg = {g,f,e,d,c,b,a}, active-high, blank in IDLE). SEG7_EN needs DIGIT_W >= 4.
module hex_sequence_player #(
   parameter int unsigned DIGIT_W = 4,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned DWELL_W = 8,
   localparam int unsigned AW     = $clog2(DEPTH),
   localparam int unsigned LW     = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               enable,
   input  logic               dir,
   input  logic               loop,
   input  logic [LW-1:0]      len,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [DIGIT_W-1:0] wr_data,
   output logic [DIGIT_W-1:0] y,
   output logic [AW-1:0]      step_idx,
   output logic               step_tick,
   output logic               busy,
   output logic               done
`ifdef SEG7_EN
   ,output logic [6:0]        seg
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [AW-1:0]        r_idx, w_idx_nxt;
   logic [DWELL_W-1:0]   r_cnt, w_cnt_nxt;
   logic [DWELL_W-1:0]   r_dwell_q, w_dwell_nxt;
   logic [LW-1:0]        r_len_q, w_len_nxt;
   logic                 r_dir_q, w_dir_nxt;
   logic                 r_loop_q, w_loop_nxt;
   logic [DIGIT_W-1:0]   r_y, w_y_nxt;
   logic                 r_tick, w_tick_nxt;
   logic [DIGIT_W-1:0]   r_table [DEPTH];

   logic [LW-1:0]        w_len_clamp;
   logic [DWELL_W-1:0]   w_dwell_eff;
   logic                 w_last;
   logic                 w_cnt_end;
   logic                 w_enter;
   logic [AW-1:0]        w_enter_idx;

   function automatic logic [DIGIT_W-1:0] default_code(input int unsigned i);
      case (i)
         0:       default_code = DIGIT_W'(4'hC);
         1:       default_code = DIGIT_W'(4'h0);
         2:       default_code = DIGIT_W'(4'hE);
         3:       default_code = DIGIT_W'(4'h3);
         4:       default_code = DIGIT_W'(4'h1);
         5:       default_code = DIGIT_W'(4'h2);
         default: default_code = '0;
      endcase
   endfunction

   assign w_len_clamp = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
   assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign w_last      = r_dir_q ? (r_idx == '0) : (r_idx == AW'(r_len_q - LW'(1)));
   assign w_cnt_end   = (r_cnt == r_dwell_q - DWELL_W'(1));

   // Code table: reset restores the default sequence, writes land in any state
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_table[i] <= default_code(i);
      end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
         r_table[wr_addr] <= wr_data;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_dwell_q <= '0;
         r_len_q   <= '0;
         r_dir_q   <= 1'b0;
         r_loop_q  <= 1'b0;
         r_y       <= '0;
         r_tick    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_cnt     <= w_cnt_nxt;
         r_dwell_q <= w_dwell_nxt;
         r_len_q   <= w_len_nxt;
         r_dir_q   <= w_dir_nxt;
         r_loop_q  <= w_loop_nxt;
         r_y       <= w_y_nxt;
         r_tick    <= w_tick_nxt;
      end
   end

   // Next state: stop beats start, start beats stepping; every step entry
   // (start, advance, wrap) shares one path that reloads cnt, y and dwell
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_dwell_nxt = r_dwell_q;
      w_len_nxt   = r_len_q;
      w_dir_nxt   = r_dir_q;
      w_loop_nxt  = r_loop_q;
      w_y_nxt     = r_y;
      w_tick_nxt  = 1'b0;
      w_enter     = 1'b0;
      w_enter_idx = r_idx;
      if (stop) begin
         w_state_nxt = S_IDLE;
         w_idx_nxt   = '0;
         w_cnt_nxt   = '0;
         w_y_nxt     = '0;
      end else if (start && (len != '0)) begin
         w_state_nxt = S_RUN;
         w_len_nxt   = w_len_clamp;
         w_dir_nxt   = dir;
         w_loop_nxt  = loop;
         w_enter     = 1'b1;
         w_enter_idx = dir ? AW'(w_len_clamp - LW'(1)) : '0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (!enable) begin
                  w_state_nxt = S_PAUSE;
               end else if (!w_cnt_end) begin
                  w_cnt_nxt = r_cnt + DWELL_W'(1);
               end else if (!w_last) begin
                  w_enter     = 1'b1;
                  w_tick_nxt  = 1'b1;
                  w_enter_idx = r_dir_q ? r_idx - AW'(1) : r_idx + AW'(1);
               end else if (r_loop_q) begin
                  w_enter     = 1'b1;
                  w_tick_nxt  = 1'b1;
                  w_enter_idx = r_dir_q ? AW'(r_len_q - LW'(1)) : '0;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
            S_PAUSE: if (enable) w_state_nxt = S_RUN;
            default: ;
         endcase
      end
      if (w_enter) begin
         w_idx_nxt   = w_enter_idx;
         w_cnt_nxt   = '0;
         w_dwell_nxt = w_dwell_eff;
         w_y_nxt     = r_table[w_enter_idx];
      end
   end

   assign y         = r_y;
   assign step_idx  = r_idx;
   assign step_tick = r_tick;
   assign busy      = (r_state == S_RUN) || (r_state == S_PAUSE);
   assign done      = (r_state == S_DONE);

`ifdef SEG7_EN
   logic [6:0] r_seg;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
      endcase
   endfunction

   // Glyph register tracks y; blank whenever the sequencer is idle
   always_ff @(posedge clk) begin
      if (!reset) r_seg <= '0;
      else        r_seg <= (w_state_nxt == S_IDLE) ? 7'h00 : glyph(w_y_nxt[3:0]);
   end

   assign seg = r_seg;
`endif

endmodule

// File: tb/tb_hex_sequence_player.sv
// Directed bench for hex_sequence_player (default build, DEPTH=8).
module tb_hex_sequence_player;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic       clk = 1'b0;
   logic       reset, start, stop, enable, dir, loop, wr_en;
   logic [3:0] len, wr_data, y;
   logic [7:0] dwell;
   logic [2:0] wr_addr, step_idx;
   logic       step_tick, busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       st, sp, en, dr, lp;
      logic [3:0] len;
      logic [7:0] dwell;
      logic       we;
      logic [2:0] wa;
      logic [3:0] wd;
      logic [3:0] ey;
      logic [2:0] eidx;
      logic       etick, ebusy, edone;
   } vec_t;

   vec_t       vecs [37];
   logic [3:0] def_seq [6];

   hex_sequence_player #(.DIGIT_W(4), .DEPTH(8), .DWELL_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable),
      .dir(dir), .loop(loop), .len(len), .dwell(dwell), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .y(y), .step_idx(step_idx),
      .step_tick(step_tick), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] ey, input logic [2:0] eidx,
                             input logic etick, input logic ebusy, input logic edone);
      check({tag, ".y"},    32'(y),         32'(ey));
      check({tag, ".idx"},  32'(step_idx),  32'(eidx));
      check({tag, ".tick"}, 32'(step_tick), 32'(etick));
      check({tag, ".busy"}, 32'(busy),      32'(ebusy));
      check({tag, ".done"}, 32'(done),      32'(edone));
   endtask

   task automatic drive(input logic st, input logic sp, input logic en, input logic dr,
                        input logic lp, input logic [3:0] ln, input logic [7:0] dw);
      start = st; stop = sp; enable = en; dir = dr; loop = lp; len = ln; dwell = dw;
   endtask

   initial begin
      def_seq[0] = 4'hC; def_seq[1] = 4'h0; def_seq[2] = 4'hE;
      def_seq[3] = 4'h3; def_seq[4] = 4'h1; def_seq[5] = 4'h2;

      //            st sp en dr lp len    dwell  we wa    wd     ey     idx   tk bs dn
      // descending one-shot, len=3 dwell=2 (restart from RUN, DONE hold, restart, stop)
      vecs[0]  = '{H, L, H, H, L, 4'd3, 8'd2, L, 3'd0, 4'h0, 4'hE, 3'd2, L, H, L};
      vecs[1]  = '{L, L, H, H, L, 4'd3, 8'd2, L, 3'd0, 4'h0, 4'hE, 3'd2, L, H, L};
      vecs[2]  = '{L, L, H, H, L, 4'd3, 8'd2, L, 3'd0, 4'h0, 4'h0, 3'd1, H, H, L};
      vecs[3]  = '{L, L, H, H, L, 4'd3, 8'd2, L, 3'd0, 4'h0, 4'h0, 3'd1, L, H, L};
      vecs[4]  = '{L, L, H, H, L, 4'd3, 8'd2, L, 3'd0, 4'h0, 4'hC, 3'd0, H, H, L};
      vecs[5]  = '{L, L, H, H, L, 4'd3, 8'd2, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[6]  = '{L, L, H, H, L, 4'd3, 8'd2, L, 3'd0, 4'h0, 4'hC, 3'd0, L, L, H};
      vecs[7]  = '{L, L, H, H, L, 4'd3, 8'd2, L, 3'd0, 4'h0, 4'hC, 3'd0, L, L, H};
      vecs[8]  = '{H, L, H, H, L, 4'd3, 8'd2, L, 3'd0, 4'h0, 4'hE, 3'd2, L, H, L};
      vecs[9]  = '{L, H, H, H, L, 4'd3, 8'd2, L, 3'd0, 4'h0, 4'h0, 3'd0, L, L, L};
      // pause: dwell=4, enable low for 5 edges after 1 counted cycle -> 4+5+1
      vecs[10] = '{H, L, H, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[11] = '{L, L, H, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[12] = '{L, L, L, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[13] = '{L, L, L, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[14] = '{L, L, L, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[15] = '{L, L, L, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[16] = '{L, L, L, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[17] = '{L, L, H, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[18] = '{L, L, H, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[19] = '{L, L, H, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[20] = '{L, L, H, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'h0, 3'd1, H, H, L};
      // table write while index 1 shown; then descending len=2 wrap, write on entry
      vecs[21] = '{L, L, H, L, H, 4'd6, 8'd4, H, 3'd1, 4'h9, 4'h0, 3'd1, L, H, L};
      vecs[22] = '{L, L, H, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'h0, 3'd1, L, H, L};
      vecs[23] = '{L, L, H, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'h0, 3'd1, L, H, L};
      vecs[24] = '{L, L, H, L, H, 4'd6, 8'd4, L, 3'd0, 4'h0, 4'hE, 3'd2, H, H, L};
      vecs[25] = '{H, L, H, H, H, 4'd2, 8'd1, L, 3'd0, 4'h0, 4'h9, 3'd1, L, H, L};
      vecs[26] = '{L, L, H, H, H, 4'd2, 8'd1, L, 3'd0, 4'h0, 4'hC, 3'd0, H, H, L};
      vecs[27] = '{L, L, H, H, H, 4'd2, 8'd1, H, 3'd1, 4'h5, 4'h9, 3'd1, H, H, L};
      vecs[28] = '{L, L, H, H, H, 4'd2, 8'd1, L, 3'd0, 4'h0, 4'hC, 3'd0, H, H, L};
      vecs[29] = '{L, L, H, H, H, 4'd2, 8'd1, L, 3'd0, 4'h0, 4'h5, 3'd1, H, H, L};
      // start+stop together, len=0 start ignored
      vecs[30] = '{H, H, H, L, L, 4'd2, 8'd1, L, 3'd0, 4'h0, 4'h0, 3'd0, L, L, L};
      vecs[31] = '{H, L, H, L, L, 4'd0, 8'd1, L, 3'd0, 4'h0, 4'h0, 3'd0, L, L, L};
      vecs[32] = '{L, L, H, L, L, 4'd0, 8'd1, L, 3'd0, 4'h0, 4'h0, 3'd0, L, L, L};
      // dwell=0 behaves as 1, one-shot len=3 -> DONE after 3 cycles
      vecs[33] = '{H, L, H, L, L, 4'd3, 8'd0, L, 3'd0, 4'h0, 4'hC, 3'd0, L, H, L};
      vecs[34] = '{L, L, H, L, L, 4'd3, 8'd0, L, 3'd0, 4'h0, 4'h5, 3'd1, H, H, L};
      vecs[35] = '{L, L, H, L, L, 4'd3, 8'd0, L, 3'd0, 4'h0, 4'hE, 3'd2, H, H, L};
      vecs[36] = '{L, L, H, L, L, 4'd3, 8'd0, L, 3'd0, 4'h0, 4'hE, 3'd2, L, L, H};

      // reset state
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      drive(L, L, L, L, L, 4'd0, 8'd0);
      cyc(); cyc();
      check_outs("reset", 4'h0, 3'd0, L, L, L);
      reset = 1'b1;
      cyc();
      check_outs("idle", 4'h0, 3'd0, L, L, L);

      // ascending loop, len=6 dwell=11: C,0,E,3,1,2,C... incl. wrap
      drive(H, L, H, L, H, 4'd6, 8'd11);
      cyc();
      check_outs("loop.start", 4'hC, 3'd0, L, H, L);
      start = 1'b0;
      for (int t = 1; t <= 77; t++) begin
         cyc();
         check($sformatf("loop.t%0d.y", t),    32'(y),         32'(def_seq[(t / 11) % 6]));
         check($sformatf("loop.t%0d.idx", t),  32'(step_idx),  32'((t / 11) % 6));
         check($sformatf("loop.t%0d.tick", t), 32'(step_tick), 32'((t % 11) == 0));
      end

      // table-driven vectors, one clock edge each
      for (int i = 0; i < 37; i++) begin
         drive(vecs[i].st, vecs[i].sp, vecs[i].en, vecs[i].dr, vecs[i].lp, vecs[i].len, vecs[i].dwell);
         wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
         cyc();
         check_outs($sformatf("vec%0d", i), vecs[i].ey, vecs[i].eidx, vecs[i].etick,
                    vecs[i].ebusy, vecs[i].edone);
      end
      wr_en = 1'b0;

      // len=12 clamps to 8 steps
      drive(H, L, H, L, L, 4'd12, 8'd1);
      cyc();
      check_outs("clamp.start", 4'hC, 3'd0, L, H, L);
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k < 8) begin
            check($sformatf("clamp.k%0d.idx", k),  32'(step_idx),  32'(k));
            check($sformatf("clamp.k%0d.tick", k), 32'(step_tick), 32'(1));
            check($sformatf("clamp.k%0d.done", k), 32'(done),      32'(0));
         end else begin
            check_outs("clamp.end", 4'h0, 3'd7, L, L, H);
         end
      end

      // reset during RUN after table writes restores the default table
      drive(H, L, H, L, H, 4'd6, 8'd3);
      cyc();
      start = 1'b0; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h7;
      cyc();
      wr_en = 1'b0;
      cyc();
      reset = 1'b0; start = 1'b1;
      cyc();
      check_outs("rst.run", 4'h0, 3'd0, L, L, L);
      reset = 1'b1; start = 1'b0;
      cyc();
      check_outs("rst.idle", 4'h0, 3'd0, L, L, L);
      drive(H, L, H, L, L, 4'd6, 8'd1);
      cyc();
      check_outs("rst.seq0", 4'hC, 3'd0, L, H, L);
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         if (k < 6) check_outs($sformatf("rst.seq%0d", k), def_seq[k], 3'(k), H, H, L);
         else       check_outs("rst.done", 4'h2, 3'd5, L, L, H);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_sequence_player.md
# hex_sequence_player

Parametrised Moore-style digit sequencer that steps through a programmable table of DIGIT_W-bit codes, holding each for a run-time dwell count. It supports forward/reverse direction, loop or one-shot mode, pause, and abort. It drives the display digit path with the code sequence (default C,0,E,3,1,2) and a step strobe for downstream logic.

## Interface
- DIGIT_W, 4, width of each table entry and of y
- DEPTH, 8, table entries (≥6); AW = $clog2(DEPTH), LW = $clog2(DEPTH+1)
- DWELL_W, 8, width of dwell input/counter
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-low; clock clk
- start  in  1  begin/restart sequence (level sampled each cycle)
- stop  in  1  abort to IDLE
- enable  in  1  1 = dwell counter advances, 0 = pause (hold)
- dir  in  1  0 = ascending index, 1 = descending; sampled at start only
- loop  in  1  1 = wrap forever, 0 = one-shot; sampled at start only
- len  in  LW  active steps; sampled at start; 0 = start ignored; >DEPTH clamped to DEPTH
- dwell  in  DWELL_W  cycles per step; sampled at each step entry; 0 treated as 1
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write index; ≥DEPTH ignored
- wr_data  in  DIGIT_W  table write data
- y  out  DIGIT_W  current code (registered)
- step_idx  out  AW  current table index
- step_tick  out  1  one-cycle pulse on every index change, incl. wrap
- busy  out  1  state is RUN or PAUSE
- done  out  1  state is DONE

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE, y=0, step_idx=0, step_tick=0, busy=0, done=0, dwell counter=0, table[0..5]=C,0,E,3,1,2, table[6..DEPTH-1]=0.
- IDLE/DONE + start (len≠0) → RUN; latch dir/loop/len_q; idx = dir ? len_q-1 : 0; cnt=0; y=table[idx]; dwell latched.
- RUN: if enable, cnt++; when cnt == dwell_q-1 and enable → step end. enable=0 → PAUSE next cycle (cnt, y frozen). PAUSE + enable=1 → RUN, counting resumes from frozen cnt.
- Step end, not last step: idx ±1, cnt=0, y=table[new idx], step_tick=1.
- Step end on last step (idx=len_q-1 ascending, idx=0 descending): loop=1 → wrap to first step, step_tick=1; loop=0 → DONE, y and step_idx hold last value, step_tick=0.
- start while RUN/PAUSE: restart exactly as from IDLE (re-sample all).
- stop in any state → IDLE, y=0, step_idx=0. stop and start same cycle: stop wins.
- Table write allowed in any state. Written value appears in y only when that index is next entered; the currently displayed y is not changed.
- Write and step entry to same index in same cycle: y takes old table data; table holds new data.
- DONE persists until start or stop; done=1 throughout.

## Timing
- start → y valid, busy=1: 1 cycle (registered).
- Each step occupies exactly max(dwell,1) enabled RUN cycles; pause cycles extend it 1:1, plus 1 cycle entering PAUSE and 0 extra leaving.
- step_tick asserted in the same cycle y shows the new code.
- One-shot total with enable=1: len_q·max(dwell,1) cycles from first y to DONE.
- reset low mid-run: next edge returns all state and table to reset values regardless of other inputs.

## Configuration
- SEG7_EN defined: adds output seg (7 bits, active-high, {g,f,e,d,c,b,a}), registered in parallel with y and showing the hex-digit glyph of y[3:0]; reset/IDLE value 7'h00 (blank). Requires DIGIT_W ≥ 4.
- SEG7_EN undefined: no seg port and no decoder logic.

## Test plan
- Reset, then len=6, dwell=11, dir=0, loop=1, enable=1, start pulse: y = C,0,E,3,1,2,C…, each held 11 cycles, step_tick every 11 cycles incl. the 2→C wrap.
- len=3, dwell=2, dir=1, loop=0: y = E,0,C, 2 cycles each, then done=1, busy=0, y stays C; a further start restarts the sequence.
- Drop enable for 5 cycles mid-step (dwell=4): step lasts 4+5+1 cycles; y frozen, no step_tick during pause.
- wr_en addr=1 data=9 while idx=1 displayed: y stays 0 until index 1 is re-entered, then shows 9.
- start and stop asserted together in RUN → IDLE, y=0. len=0 start → remains IDLE. len=12 with DEPTH=8 → 8 steps.
- reset low during RUN after a table write → y=0, IDLE, table restored to the C,0,E,3,1,2 default (with SEG7_EN: seg=7'h00, then glyph for C=7'h39 after start).
